// File: rtl/bus_decode_pkg.sv
// Shared definitions for the bus_decode address decoder / demux.
// Holds the FSM state encoding, response codes, the bus word width and
// a helper to size target-select fields.
package bus_decode_pkg;

  localparam int unsigned BusWidth = 32;

  // Response code carried on inerr
  localparam logic ErrOk  = 1'b0;
  localparam logic ErrErr = 1'b1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  // Width of a target index; at least one bit even for a single target
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_decode_if.sv
// Simple request/ack bus as seen by the decoder: the upstream in* side
// (from the bridge) and the fan-out tgt* side (to NTGT targets).
//   slave  : decoder view (receives in* requests, drives tgt* requests)
//   master : environment view (bridge + targets)
interface bus_decode_if
  import bus_decode_pkg::*;
#(
  parameter int unsigned NTGT = 4
);
  // Upstream side
  logic [BusWidth-1:0]      inaddr;
  logic [BusWidth-1:0]      inwdata;
  logic [3:0]               inwstrb;
  logic                     inwr;
  logic                     inreq;
  logic                     inack;
  logic                     inerr;
  logic [BusWidth-1:0]      inrdata;
  // Target side
  logic [BusWidth-1:0]      tgtaddr;
  logic [BusWidth-1:0]      tgtwdata;
  logic [3:0]               tgtwstrb;
  logic                     tgtwr;
  logic [NTGT-1:0]          tgtreq;
  logic [NTGT-1:0]          tgtack;
  logic [NTGT-1:0]          tgterr;
  logic [BusWidth*NTGT-1:0] tgtrdata;

  modport slave (
    input  inaddr, inwdata, inwstrb, inwr, inreq,
    output inack, inerr, inrdata,
    output tgtaddr, tgtwdata, tgtwstrb, tgtwr, tgtreq,
    input  tgtack, tgterr, tgtrdata
  );

  modport master (
    output inaddr, inwdata, inwstrb, inwr, inreq,
    input  inack, inerr, inrdata,
    input  tgtaddr, tgtwdata, tgtwstrb, tgtwr, tgtreq,
    output tgtack, tgterr, tgtrdata
  );

endinterface

// File: rtl/bus_decode_match.sv
// Combinational base/mask address match with priority encoding.
//   addr_i : address to decode
//   hit_o  : some target matches
//   sel_o  : lowest-index matching target (0 when no hit)
module bus_decode_match
  import bus_decode_pkg::*;
#(
  parameter int unsigned            NTGT = 4,
  parameter logic [32*NTGT-1:0]     BASE = '0,
  parameter logic [32*NTGT-1:0]     MASK = '0,
  parameter int unsigned            SelW = sel_width(NTGT)
) (
  input  logic [BusWidth-1:0] addr_i,
  output logic                hit_o,
  output logic [SelW-1:0]     sel_o
);

  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int unsigned i = 0; i < NTGT; i++) begin
      // First match sticks, so the lowest index wins on overlap
      if (!hit_o && ((addr_i & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
        hit_o = 1'b1;
        sel_o = SelW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_decode.sv
// Address decoder and demux for the simple request/ack bus.
// Forwards each single-beat request to the matching target, returns that
// target's ack/err/rdata upstream, and answers unmapped addresses with an
// error itself.
//   clk      : clock
//   rst      : synchronous active-high reset
//   bus      : bus_decode_if.slave (in* upstream side, tgt* target side)
//   protoerr : sticky, set when inreq arrives while a transfer is pending
// Optional build macro BUS_DECODE_TIMEOUT_EN adds a TIMEOUT-cycle watchdog
// that completes a stuck transfer with an error.
module bus_decode
  import bus_decode_pkg::*;
#(
  parameter int unsigned        NTGT    = 4,
  parameter logic [32*NTGT-1:0] BASE    = {32'h4000_0000, 32'h0002_0000,
                                           32'h0001_0000, 32'h0000_0000},
  parameter logic [32*NTGT-1:0] MASK    = {32'hF000_0000, 32'hFFFF_0000,
                                           32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned        TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  bus_decode_if.slave  bus,
  output logic         protoerr
);

  localparam int unsigned SelW = sel_width(NTGT);

  logic            hit;
  logic [SelW-1:0] sel_dec;

  bus_decode_match #(
    .NTGT (NTGT),
    .BASE (BASE),
    .MASK (MASK),
    .SelW (SelW)
  ) u_match (
    .addr_i (bus.inaddr),
    .hit_o  (hit),
    .sel_o  (sel_dec)
  );

  state_e              state_q, state_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic                inack_q, inack_d;
  logic                inerr_q, inerr_d;
  logic [BusWidth-1:0] inrdata_q, inrdata_d;
  logic [NTGT-1:0]     tgtreq_q, tgtreq_d;
  logic [BusWidth-1:0] tgtaddr_q, tgtaddr_d;
  logic [BusWidth-1:0] tgtwdata_q, tgtwdata_d;
  logic [3:0]          tgtwstrb_q, tgtwstrb_d;
  logic                tgtwr_q, tgtwr_d;
  logic                protoerr_q, protoerr_d;

`ifdef BUS_DECODE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Response of the currently selected target
  logic                ack_sel;
  logic                err_sel;
  logic [BusWidth-1:0] rdata_sel;

  always_comb begin
    ack_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NTGT; i++) begin
      if (sel_q == SelW'(i)) begin
        ack_sel   = bus.tgtack[i];
        err_sel   = bus.tgterr[i];
        rdata_sel = bus.tgtrdata[BusWidth*i +: BusWidth];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    inack_d    = 1'b0;
    inerr_d    = inerr_q;
    inrdata_d  = inrdata_q;
    tgtreq_d   = '0;
    tgtaddr_d  = tgtaddr_q;
    tgtwdata_d = tgtwdata_q;
    tgtwstrb_d = tgtwstrb_q;
    tgtwr_d    = tgtwr_q;
    protoerr_d = protoerr_q;
`ifdef BUS_DECODE_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.inreq) begin
          if (hit) begin
            tgtaddr_d  = bus.inaddr;
            tgtwdata_d = bus.inwdata;
            tgtwstrb_d = bus.inwstrb;
            tgtwr_d    = bus.inwr;
            sel_d      = sel_dec;
            tgtreq_d   = NTGT'(1) << sel_dec;
            state_d    = StWait;
`ifdef BUS_DECODE_TIMEOUT_EN
            cnt_d      = CntW'(TIMEOUT);
`endif
          end else begin
            inack_d   = 1'b1;
            inerr_d   = ErrErr;
            inrdata_d = '0;
          end
        end
      end
      StWait: begin
        // A request while busy is dropped, only flagged
        if (bus.inreq) begin
          protoerr_d = 1'b1;
        end
        if (ack_sel) begin
          inack_d   = 1'b1;
          inerr_d   = err_sel;
          inrdata_d = rdata_sel;
          state_d   = StIdle;
        end
`ifdef BUS_DECODE_TIMEOUT_EN
        else if (cnt_q == '0) begin
          inack_d   = 1'b1;
          inerr_d   = ErrErr;
          inrdata_d = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      inack_q    <= 1'b0;
      inerr_q    <= ErrOk;
      inrdata_q  <= '0;
      tgtreq_q   <= '0;
      tgtaddr_q  <= '0;
      tgtwdata_q <= '0;
      tgtwstrb_q <= '0;
      tgtwr_q    <= 1'b0;
      protoerr_q <= 1'b0;
`ifdef BUS_DECODE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      inack_q    <= inack_d;
      inerr_q    <= inerr_d;
      inrdata_q  <= inrdata_d;
      tgtreq_q   <= tgtreq_d;
      tgtaddr_q  <= tgtaddr_d;
      tgtwdata_q <= tgtwdata_d;
      tgtwstrb_q <= tgtwstrb_d;
      tgtwr_q    <= tgtwr_d;
      protoerr_q <= protoerr_d;
`ifdef BUS_DECODE_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.inack    = inack_q;
  assign bus.inerr    = inerr_q;
  assign bus.inrdata  = inrdata_q;
  assign bus.tgtreq   = tgtreq_q;
  assign bus.tgtaddr  = tgtaddr_q;
  assign bus.tgtwdata = tgtwdata_q;
  assign bus.tgtwstrb = tgtwstrb_q;
  assign bus.tgtwr    = tgtwr_q;
  assign protoerr     = protoerr_q;

endmodule

// File: tb/tb_bus_decode.sv
// Self-checking bench for bus_decode: random traffic against an address-map
// reference model, a scoreboard of expected upstream responses popped by a
// monitor, a target responder that checks forwarded requests, plus directed
// cases (stray acks, busy requests, reset mid-transfer, overlap priority and,
// with BUS_DECODE_TIMEOUT_EN, the watchdog).
module tb_bus_decode;
  import bus_decode_pkg::*;

  localparam int unsigned NTGT = 4;
  localparam logic [32*NTGT-1:0] BASE = {32'h4000_0000, 32'h0002_0000,
                                         32'h0001_0000, 32'h0000_0000};
  localparam logic [32*NTGT-1:0] MASK = {32'hF000_0000, 32'hFFFF_0000,
                                         32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [32*NTGT-1:0] BASE_OV = {32'h4000_0000, 32'h0002_0000,
                                            32'h0001_0000, 32'h0000_0000};
  localparam logic [32*NTGT-1:0] MASK_OV = {32'hF000_0000, 32'hFFFF_0000,
                                            32'hFFFF_0000, 32'h0000_0000};
`ifdef BUS_DECODE_TIMEOUT_EN
  localparam int unsigned TO = 15;
`else
  localparam int unsigned TO = 1023;
`endif

  // Address map as the bench understands it
  logic [31:0] ref_base [NTGT] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h4000_0000};
  logic [31:0] ref_mask [NTGT] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    int          tgt;
    logic        err;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
  } plan_t;

  exp_t  exp_q  [$];
  plan_t plan_q [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic                protoerr, protoerr2;
  logic [NTGT-1:0]     resp_ack, stray_ack, resp_err;
  logic [32*NTGT-1:0]  resp_rdata;

  bus_decode_if #(.NTGT(NTGT)) bus ();
  bus_decode_if #(.NTGT(NTGT)) bus2 ();

  assign bus.tgtack   = resp_ack | stray_ack;
  assign bus.tgterr   = resp_err;
  assign bus.tgtrdata = resp_rdata;

  bus_decode #(.NTGT(NTGT), .BASE(BASE), .MASK(MASK), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .protoerr (protoerr)
  );

  bus_decode #(.NTGT(NTGT), .BASE(BASE_OV), .MASK(MASK_OV), .TIMEOUT(TO)) dut_ov (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus2),
    .protoerr (protoerr2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NTGT; i++) begin
      if ((a & ref_mask[i]) == ref_base[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return {16'h0000, 16'($urandom)};
      1:       return {16'h0001, 16'($urandom)};
      2:       return {16'h0002, 16'($urandom)};
      3:       return {4'h4, 28'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every inack must match the oldest expected response and cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.inack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_inack: got inack=1 rdata %h err %b, expected no response (cycle %0d)",
                 bus.inrdata, bus.inerr, cyc);
      end else begin
        e = exp_q.pop_front();
        check("inerr", 32'(bus.inerr), 32'(e.err));
        check("inrdata", bus.inrdata, e.rdata);
        check("inack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Target responder: checks each forwarded request and acks per plan
  initial begin : responder
    plan_t p;
    resp_ack   = '0;
    resp_err   = '0;
    resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.tgtreq != '0) begin
        if (plan_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tgtreq: got tgtreq %b, expected none (cycle %0d)",
                   bus.tgtreq, cyc);
        end else begin
          p = plan_q.pop_front();
          check("tgtreq", 32'(bus.tgtreq), 32'(1) << p.tgt);
          check("tgtaddr", bus.tgtaddr, p.addr);
          check("tgtwdata", bus.tgtwdata, p.wdata);
          check("tgtwstrb", 32'(bus.tgtwstrb), 32'(p.wstrb));
          check("tgtwr", 32'(bus.tgtwr), 32'(p.wr));
          if (p.delay != 0) begin
            @(negedge clk);
            check("tgtreq_pulse", 32'(bus.tgtreq), 32'h0);
            repeat (p.delay - 1) @(negedge clk);
          end
          // Non-selected lanes carry junk so a wrong mux shows up
          resp_rdata = {$urandom, $urandom, $urandom, $urandom};
          resp_rdata[32*p.tgt +: 32] = p.rdata;
          resp_err = 4'($urandom);
          resp_err[p.tgt] = p.err;
          resp_ack[p.tgt] = 1'b1;
          @(negedge clk);
          if (p.delay == 0) check("tgtreq_pulse", 32'(bus.tgtreq), 32'h0);
          resp_ack = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                           input logic w);
    bus.inaddr  = a;
    bus.inwdata = wd;
    bus.inwstrb = st;
    bus.inwr    = w;
    bus.inreq   = 1'b1;
    step();
    bus.inreq   = 1'b0;
  endtask

  // Issue one request; lat = cycles from inreq to inack
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic w, input int delay, input logic terr,
                       input logic [31:0] trd, output int lat);
    int t;
    t = ref_decode(a);
    if (t < 0) begin
      exp_q.push_back('{1'b1, 32'h0, cyc + 1});
      lat = 1;
    end else begin
      plan_q.push_back('{t, terr, trd, delay, a, wd, st, w});
      exp_q.push_back('{terr, trd, cyc + delay + 2});
      lat = delay + 2;
    end
    drive_req(a, wd, st, w);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL response_timeout: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inack"}, 32'(bus.inack), 32'h0);
    check({tag, "_inerr"}, 32'(bus.inerr), 32'h0);
    check({tag, "_inrdata"}, bus.inrdata, 32'h0);
    check({tag, "_tgtreq"}, 32'(bus.tgtreq), 32'h0);
    check({tag, "_tgtaddr"}, bus.tgtaddr, 32'h0);
    check({tag, "_tgtwdata"}, bus.tgtwdata, 32'h0);
    check({tag, "_tgtwstrb"}, 32'(bus.tgtwstrb), 32'h0);
    check({tag, "_tgtwr"}, 32'(bus.tgtwr), 32'h0);
    check({tag, "_protoerr"}, 32'(protoerr), 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stimulus
    int lat;
    logic [31:0] a;
    logic [31:0] ov_addr [2];
    bus.inaddr = '0; bus.inwdata = '0; bus.inwstrb = '0; bus.inwr = 1'b0; bus.inreq = 1'b0;
    bus2.inaddr = '0; bus2.inwdata = '0; bus2.inwstrb = '0; bus2.inwr = 1'b0;
    bus2.inreq = 1'b0; bus2.tgtack = '0; bus2.tgterr = '0; bus2.tgtrdata = '0;
    stray_ack = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Directed reads/writes from the map
    issue(32'h0001_0004, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'hDEAD_BEEF, lat);
    wait_idle();
    issue(32'h4000_0010, 32'h1234_5678, 4'b0011, 1'b1, 1, 1'b1, 32'h0, lat);
    wait_idle();
    issue(32'h8000_0000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 32'h0, lat);
    wait_idle();

    // Random traffic, sometimes back-to-back with the previous inack
    for (int k = 0; k < 60; k++) begin
      a = rand_addr();
      issue(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 4), 1'($urandom),
            $urandom, lat);
      if ($urandom_range(0, 2) == 0) begin
        repeat (lat - 1) step();
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 2)) step();
      end
    end
    wait_idle();
    check("protoerr_clean", 32'(protoerr), 32'h0);

    // Stray ack from another target and a request while busy
    issue(32'h0002_0040, 32'hA5A5_0000, 4'hF, 1'b0, 6, 1'b0, 32'h2222_3333, lat);
    step();
    stray_ack = 4'b0010;
    step();
    stray_ack = '0;
    bus.inaddr = 32'h0001_0000;
    bus.inreq  = 1'b1;
    step();
    bus.inreq  = 1'b0;
    @(negedge clk);
    check("busy_protoerr", 32'(protoerr), 32'h1);
    check("busy_no_tgtreq", 32'(bus.tgtreq), 32'h0);
    wait_idle();
    check("protoerr_sticky", 32'(protoerr), 32'h1);

    // Reset mid-transfer: the later ack must be ignored
    plan_q.push_back('{0, 1'b0, 32'hCAFE_0000, 5, 32'h0000_1234, 32'h5555_AAAA, 4'hC, 1'b1});
    drive_req(32'h0000_1234, 32'h5555_AAAA, 4'hC, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (10) step();
    issue(32'h0002_0008, 32'h0, 4'h0, 1'b0, 0, 1'b0, 32'h7777_8888, lat);
    wait_idle();

`ifdef BUS_DECODE_TIMEOUT_EN
    // Target never answers in time; late ack must be ignored
    plan_q.push_back('{0, 1'b0, 32'h1111_1111, 30, 32'h0000_0100, 32'h0, 4'h0, 1'b0});
    exp_q.push_back('{1'b1, 32'h0, cyc + 17});
    drive_req(32'h0000_0100, 32'h0, 4'h0, 1'b0);
    repeat (40) step();
    check("timeout_drained", 32'(exp_q.size()), 32'h0);
    // Ack in the same cycle the count expires wins
    issue(32'h0000_0200, 32'h0, 4'h0, 1'b0, 15, 1'b0, 32'hA5A5_5A5A, lat);
    wait_idle();
`endif

    // Overlapping map: target 0 matches everything and must win
    ov_addr[0] = 32'h0002_0000;
    ov_addr[1] = 32'h4000_0010;
    for (int k = 0; k < 2; k++) begin
      bus2.inaddr = ov_addr[k];
      bus2.inreq  = 1'b1;
      step();
      bus2.inreq  = 1'b0;
      @(negedge clk);
      check("overlap_tgtreq", 32'(bus2.tgtreq), 32'h1);
      bus2.tgtack   = 4'b0001;
      bus2.tgtrdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_F00D + 32'(k)};
      @(negedge clk);
      bus2.tgtack   = '0;
      check("overlap_inack", 32'(bus2.inack), 32'h1);
      check("overlap_inrdata", bus2.inrdata, 32'h0BAD_F00D + 32'(k));
      step();
    end

    repeat (5) step();
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("plan_q_empty", 32'(plan_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
